// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS main controller: sequences each instruction over 3-5 cycles
// and drives datapath enables/mux selects; memory accesses stall on mem_ready.
module mips_multicycle_controller #(
  parameter int OP_W         = 6,
  parameter bit EN_BNE       = 1'b1,
  parameter bit EN_LOGIC_IMM = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] Op,
  input  logic            mem_ready,
  output logic            IorD,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      ImmSel,
  output logic            ZeroExt,
  output logic [1:0]      PCSrc,
  output logic            PCWrite,
  output logic            Branch,
  output logic            BranchNe,
  output logic            illegal_op,
  output logic [3:0]      state_o
);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
    MEMWB = 4'd4, MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7,
    BRANCH = 4'd8, IEXEC = 4'd9, IWB = 4'd10, JUMP = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  state_t          state, next;
  logic [OP_W-1:0] op_q;
  logic            is_logic_imm;

  assign is_logic_imm = EN_LOGIC_IMM && (Op == OP_ANDI || Op == OP_ORI || Op == OP_SLTI);
  assign state_o      = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      op_q  <= '0;
    end else begin
      state <= next;
      if (state == DECODE) op_q <= Op;
    end
  end

  always_comb begin
    next       = state;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    ImmSel     = 2'b00;
    ZeroExt    = 1'b0;
    PCSrc      = 2'b00;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    BranchNe   = 1'b0;
    illegal_op = 1'b0;
    // Holding everything at default while rst is high keeps an abandoned
    // instruction from issuing any write during the reset window.
    if (!rst) begin
      case (state)
        FETCH: begin
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          if (mem_ready) next = DECODE;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          if (Op == OP_R)                             next = EXEC;
          else if (Op == OP_LW || Op == OP_SW)        next = MEMADR;
          else if (Op == OP_BEQ || (EN_BNE && Op == OP_BNE)) next = BRANCH;
          else if (Op == OP_ADDI || is_logic_imm)     next = IEXEC;
          else if (Op == OP_J)                        next = JUMP;
          else begin
            illegal_op = 1'b1;
            next       = FETCH;
          end
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          next    = (op_q == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          IorD = 1'b1;
          if (mem_ready) next = MEMWB;
        end
        MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
          next     = FETCH;
        end
        MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          if (mem_ready) next = FETCH;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          next    = ALUWB;
        end
        ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
          next     = FETCH;
        end
        BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b01;
          PCSrc    = 2'b01;
          Branch   = (op_q == OP_BEQ);
          BranchNe = EN_BNE && (op_q == OP_BNE);
          next     = FETCH;
        end
        IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          next    = IWB;
          if (EN_LOGIC_IMM) begin
            case (op_q)
              OP_ANDI: begin ALUOp = 2'b11; ImmSel = 2'b01; ZeroExt = 1'b1; end
              OP_ORI:  begin ALUOp = 2'b11; ImmSel = 2'b10; ZeroExt = 1'b1; end
              OP_SLTI: begin ALUOp = 2'b11; ImmSel = 2'b11; end
              default: ALUOp = 2'b00;
            endcase
          end
        end
        IWB: begin
          RegWrite = 1'b1;
          next     = FETCH;
        end
        JUMP: begin
          PCSrc   = 2'b10;
          PCWrite = 1'b1;
          next    = FETCH;
        end
        default: next = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench: two controllers (all extensions on / all off) driven with
// random instruction streams; expected per-cycle outputs come from a phase model.
module tb_mips_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, immsel;
    logic zeroext;
    logic [1:0] pcsrc;
    logic pcwrite, branch, branchne, illegal;
  } exp_t;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_IEXEC = 9,
                 S_IWB = 10, S_JUMP = 11;
  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_BNE = 4, C_ADDI = 5,
                 C_ANDI = 6, C_ORI = 7, C_SLTI = 8, C_J = 9, C_ILL = 10;

  logic       clk = 1'b0;
  logic       rst [2];
  logic [5:0] op  [2];
  logic       mr  [2];
  logic       iord [2], memwrite [2], irwrite [2], regdst [2], memtoreg [2], regwrite [2];
  logic       alusrca [2], zeroext [2], pcwrite [2], branch [2], branchne [2], illegal [2];
  logic [1:0] alusrcb [2], aluop [2], immsel [2], pcsrc [2];
  logic [3:0] st_o [2];
  exp_t       act [2];
  exp_t       q0 [$], q1 [$];
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_controller #(.OP_W(6), .EN_BNE(1'b1), .EN_LOGIC_IMM(1'b1)) dut0 (
    .clk(clk), .rst(rst[0]), .Op(op[0]), .mem_ready(mr[0]), .IorD(iord[0]),
    .MemWrite(memwrite[0]), .IRWrite(irwrite[0]), .RegDst(regdst[0]), .MemtoReg(memtoreg[0]),
    .RegWrite(regwrite[0]), .ALUSrcA(alusrca[0]), .ALUSrcB(alusrcb[0]), .ALUOp(aluop[0]),
    .ImmSel(immsel[0]), .ZeroExt(zeroext[0]), .PCSrc(pcsrc[0]), .PCWrite(pcwrite[0]),
    .Branch(branch[0]), .BranchNe(branchne[0]), .illegal_op(illegal[0]), .state_o(st_o[0]));

  mips_multicycle_controller #(.OP_W(6), .EN_BNE(1'b0), .EN_LOGIC_IMM(1'b0)) dut1 (
    .clk(clk), .rst(rst[1]), .Op(op[1]), .mem_ready(mr[1]), .IorD(iord[1]),
    .MemWrite(memwrite[1]), .IRWrite(irwrite[1]), .RegDst(regdst[1]), .MemtoReg(memtoreg[1]),
    .RegWrite(regwrite[1]), .ALUSrcA(alusrca[1]), .ALUSrcB(alusrcb[1]), .ALUOp(aluop[1]),
    .ImmSel(immsel[1]), .ZeroExt(zeroext[1]), .PCSrc(pcsrc[1]), .PCWrite(pcwrite[1]),
    .Branch(branch[1]), .BranchNe(branchne[1]), .illegal_op(illegal[1]), .state_o(st_o[1]));

  always_comb begin
    for (int i = 0; i < 2; i++)
      act[i] = '{st: st_o[i], iord: iord[i], memwrite: memwrite[i], irwrite: irwrite[i],
                 regdst: regdst[i], memtoreg: memtoreg[i], regwrite: regwrite[i],
                 alusrca: alusrca[i], alusrcb: alusrcb[i], aluop: aluop[i], immsel: immsel[i],
                 zeroext: zeroext[i], pcsrc: pcsrc[i], pcwrite: pcwrite[i], branch: branch[i],
                 branchne: branchne[i], illegal: illegal[i]};
  end

  task automatic chk(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s state=%0d got=%h want=%h", name, want.st, got, want);
    end
  endtask

  // Instruction class from the opcode, honouring which extensions the DUT has.
  function automatic int cls_of(input logic [5:0] o, input bit bne, input bit li);
    case (o)
      6'b000000: return C_R;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000101: return bne ? C_BNE : C_ILL;
      6'b001000: return C_ADDI;
      6'b001100: return li ? C_ANDI : C_ILL;
      6'b001101: return li ? C_ORI : C_ILL;
      6'b001010: return li ? C_SLTI : C_ILL;
      6'b000010: return C_J;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic exp_t exp_of(input int s, input int cls, input logic m);
    exp_t e = '0;
    e.st = 4'(s);
    case (s)
      S_FETCH:  begin e.alusrcb = 2'b01; e.irwrite = m; e.pcwrite = m; end
      S_DECODE: begin e.alusrcb = 2'b11; e.illegal = (cls == C_ILL); end
      S_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      S_MEMRD:  e.iord = 1;
      S_MEMWB:  begin e.memtoreg = 1; e.regwrite = 1; end
      S_MEMWR:  begin e.iord = 1; e.memwrite = 1; end
      S_EXEC:   begin e.alusrca = 1; e.aluop = 2'b10; end
      S_ALUWB:  begin e.regdst = 1; e.regwrite = 1; end
      S_BRANCH: begin
        e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01;
        e.branch = (cls == C_BEQ); e.branchne = (cls == C_BNE);
      end
      S_IEXEC: begin
        e.alusrca = 1; e.alusrcb = 2'b10;
        if (cls == C_ANDI) begin e.aluop = 2'b11; e.immsel = 2'b01; e.zeroext = 1; end
        if (cls == C_ORI)  begin e.aluop = 2'b11; e.immsel = 2'b10; e.zeroext = 1; end
        if (cls == C_SLTI) begin e.aluop = 2'b11; e.immsel = 2'b11; end
      end
      S_IWB:  e.regwrite = 1;
      S_JUMP: begin e.pcsrc = 2'b10; e.pcwrite = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // One clock of stimulus: inputs applied just after the edge, expectation queued.
  task automatic cyc(input int d, input logic [5:0] o, input logic m, input exp_t e);
    @(posedge clk); #1;
    op[d] = o;
    mr[d] = m;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Walk one instruction through its phases; memory phases stall for
  // fstall/mstall cycles (negative = random). Op is scrambled after DECODE.
  task automatic run_instr(input int d, input logic [5:0] opc, input int fstall, input int mstall);
    int ph[$];
    int cls, w;
    logic m;
    logic [5:0] o;
    cls = cls_of(opc, d == 0, d == 0);
    ph = '{S_FETCH, S_DECODE};
    case (cls)
      C_R:                         begin ph.push_back(S_EXEC); ph.push_back(S_ALUWB); end
      C_LW:                        begin ph.push_back(S_MEMADR); ph.push_back(S_MEMRD); ph.push_back(S_MEMWB); end
      C_SW:                        begin ph.push_back(S_MEMADR); ph.push_back(S_MEMWR); end
      C_BEQ, C_BNE:                ph.push_back(S_BRANCH);
      C_ADDI, C_ANDI, C_ORI, C_SLTI: begin ph.push_back(S_IEXEC); ph.push_back(S_IWB); end
      C_J:                         ph.push_back(S_JUMP);
      default: ;
    endcase
    foreach (ph[i]) begin
      if (ph[i] == S_FETCH)                         w = (fstall < 0) ? int'($urandom_range(0, 1)) : fstall;
      else if (ph[i] == S_MEMRD || ph[i] == S_MEMWR) w = (mstall < 0) ? int'($urandom_range(0, 2)) : mstall;
      else                                          w = -1;
      for (int k = 0; k <= ((w < 0) ? 0 : w); k++) begin
        m = (w < 0) ? 1'($urandom) : (k == w);
        o = (ph[i] <= S_DECODE) ? opc : 6'($urandom);
        cyc(d, o, m, exp_of(ph[i], cls, m));
      end
    end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] pool [10] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h02};
    if ($urandom_range(0, 4) == 0) return 6'($urandom);
    return pool[$urandom_range(0, 9)];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin e = q0.pop_front(); chk("dut0_cycle", act[0], e); end
    if (q1.size() > 0) begin e = q1.pop_front(); chk("dut1_cycle", act[1], e); end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin rst[i] = 1; op[i] = '0; mr[i] = 1; end
    #2;
    chk("reset_dut0", act[0], '0);
    chk("reset_dut1", act[1], '0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    mr[0] = 0; mr[1] = 0;
    rst[0] = 0; rst[1] = 0;
    #1;
    chk("reset_release", act[0], exp_of(S_FETCH, C_R, 0));
    fork
      begin
        run_instr(0, 6'b100011, 0, 0);   // LW, 5 cycles
        run_instr(0, 6'b101011, 0, 3);   // SW with 3 stall cycles
        run_instr(0, 6'b000101, 0, 0);   // BNE
        run_instr(0, 6'b001101, 0, 0);   // ORI
        run_instr(0, 6'b000010, 0, 0);   // J, Op scrambled in JUMP
        // R-type abandoned by an asynchronous reset in EXEC
        cyc(0, 6'h00, 1, exp_of(S_FETCH, C_R, 1));
        cyc(0, 6'h00, 1, exp_of(S_DECODE, C_R, 1));
        cyc(0, 6'h2b, 1, exp_of(S_EXEC, C_R, 1));
        @(negedge clk); #1;
        rst[0] = 1;
        #1 chk("rst_async", act[0], '0);
        @(posedge clk); #2;
        chk("rst_hold", act[0], '0);
        mr[0] = 0;
        @(negedge clk); #1;
        rst[0] = 0;
        #1 chk("rst_deassert", act[0], exp_of(S_FETCH, C_R, 0));
        run_instr(0, 6'b000100, 1, 0);
        run_instr(0, 6'b001000, 0, 0);
        run_instr(0, 6'b001100, 0, 0);
        run_instr(0, 6'b001010, 0, 0);
        run_instr(0, 6'b111111, 0, 0);
        for (int n = 0; n < 60; n++) run_instr(0, rand_op(), -1, -1);
      end
      begin
        run_instr(1, 6'b000101, 0, 0);   // BNE disabled -> illegal
        run_instr(1, 6'b001100, 0, 0);
        run_instr(1, 6'b001101, 0, 0);
        run_instr(1, 6'b001010, 0, 0);
        run_instr(1, 6'b000100, 0, 0);
        run_instr(1, 6'b001000, 0, 0);
        run_instr(1, 6'b100011, 2, 1);
        for (int n = 0; n < 60; n++) run_instr(1, rand_op(), -1, -1);
      end
    join
    repeat (2) @(posedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d want=0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
